// File: rtl/pu_msp430_ram_bist.sv
// March C- self-test engine for a word-organised MSP430 RAM port.
// Element order: M0 up(wP), M1 up(rP,wQ), M2 up(rQ,wP), M3 down(rP,wQ),
// M4 down(rQ,wP), M5 up(rP). Stops and reports on the first mismatch.
module pu_msp430_ram_bist #(
  parameter int          ADDR_MSB = 6,
  parameter int          MEM_SIZE = 256,
  parameter logic [15:0] DATA_BG  = 16'h0000
) (
  input  logic                mclk,
  input  logic                reset_n,
  input  logic                bist_start,
  output logic                bist_busy,
  output logic                bist_done,
  output logic                bist_fail,
  output logic [ADDR_MSB:0]   bist_fail_addr,
  output logic [15:0]         bist_fail_exp,
  output logic [15:0]         bist_fail_act,
  output logic [ADDR_MSB:0]   ram_addr,
  output logic                ram_cen,
  output logic [1:0]          ram_wen,
  output logic [15:0]         ram_din,
  input  logic [15:0]         ram_dout
);

  localparam int              AW     = ADDR_MSB + 1;
  localparam int              N      = MEM_SIZE / 2;
  localparam logic [AW-1:0]   A_LAST = AW'(N - 1);
  localparam logic [AW-1:0]   A_ZERO = '0;
  localparam logic [15:0]     PAT_P  = DATA_BG;
  localparam logic [15:0]     PAT_Q  = ~DATA_BG;

  typedef enum logic [2:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DONE
  } state_t;

  // r_state/r_addr/r_ph describe the access currently on the RAM port;
  // r_ph=0 is the read half, r_ph=1 the write half (M5: final compare-only cycle).
  state_t          r_state;
  logic [AW-1:0]   r_addr;
  logic            r_ph;
  logic            r_rd_pend;
  logic [AW-1:0]   r_rd_addr;

  state_t          w_nstate;
  logic [AW-1:0]   w_naddr;
  logic            w_nph;
  logic            w_start;
  logic            w_cmp_en;
  logic [15:0]     w_cmp_exp;
  logic [AW-1:0]   w_cmp_addr;
  logic            w_mis;
  logic            w_cen;
  logic [1:0]      w_wen;
  logic [AW-1:0]   w_aout;
  logic [15:0]     w_din;

  // Next-state sequencing and read-data compare for the access in flight
  always_comb begin
    w_nstate   = r_state;
    w_naddr    = r_addr;
    w_nph      = r_ph;
    w_start    = 1'b0;
    w_cmp_en   = 1'b0;
    w_cmp_exp  = PAT_P;
    w_cmp_addr = r_addr;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bist_start) begin
          w_start  = 1'b1;
          w_nstate = S_M0;
          w_naddr  = A_ZERO;
          w_nph    = 1'b0;
        end
      end
      S_M0: begin
        if (r_addr == A_LAST) begin
          w_nstate = S_M1;
          w_naddr  = A_ZERO;
        end else begin
          w_naddr = r_addr + 1'b1;
        end
      end
      S_M1, S_M2: begin
        if (!r_ph) begin
          w_nph = 1'b1;
        end else begin
          w_cmp_en  = 1'b1;
          w_cmp_exp = (r_state == S_M1) ? PAT_P : PAT_Q;
          w_nph     = 1'b0;
          if (r_addr == A_LAST) begin
            w_nstate = (r_state == S_M1) ? S_M2 : S_M3;
            w_naddr  = (r_state == S_M1) ? A_ZERO : A_LAST;
          end else begin
            w_naddr = r_addr + 1'b1;
          end
        end
      end
      S_M3, S_M4: begin
        if (!r_ph) begin
          w_nph = 1'b1;
        end else begin
          w_cmp_en  = 1'b1;
          w_cmp_exp = (r_state == S_M3) ? PAT_P : PAT_Q;
          w_nph     = 1'b0;
          if (r_addr == A_ZERO) begin
            w_nstate = (r_state == S_M3) ? S_M4 : S_M5;
            w_naddr  = (r_state == S_M3) ? A_LAST : A_ZERO;
          end else begin
            w_naddr = r_addr - 1'b1;
          end
        end
      end
      S_M5: begin
        w_cmp_en   = r_rd_pend;
        w_cmp_exp  = PAT_P;
        w_cmp_addr = r_rd_addr;
        if (!r_ph) begin
          if (r_addr == A_LAST) w_nph = 1'b1;
          else                  w_naddr = r_addr + 1'b1;
        end else begin
          w_nstate = S_DONE;
          w_naddr  = A_ZERO;
          w_nph    = 1'b0;
        end
      end
      default: begin
        w_nstate = S_IDLE;
        w_naddr  = A_ZERO;
        w_nph    = 1'b0;
      end
    endcase
    w_mis = w_cmp_en && (ram_dout != w_cmp_exp);
    if (w_mis) begin
      w_nstate = S_DONE;
      w_naddr  = A_ZERO;
      w_nph    = 1'b0;
    end
  end

  // Decode the RAM port drive for the access about to be presented
  always_comb begin
    w_cen  = 1'b1;
    w_wen  = 2'b11;
    w_aout = A_ZERO;
    w_din  = 16'h0000;
    case (w_nstate)
      S_M0: begin
        w_cen  = 1'b0;
        w_wen  = 2'b00;
        w_aout = w_naddr;
        w_din  = PAT_P;
      end
      S_M1, S_M2, S_M3, S_M4: begin
        w_cen  = 1'b0;
        w_aout = w_naddr;
        if (w_nph) begin
          w_wen = 2'b00;
          w_din = ((w_nstate == S_M1) || (w_nstate == S_M3)) ? PAT_Q : PAT_P;
        end
      end
      S_M5: begin
        if (!w_nph) begin
          w_cen  = 1'b0;
          w_aout = w_naddr;
        end
      end
      default: ;
    endcase
  end

  // State, registered RAM port and status/fail capture
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_ph           <= 1'b0;
      r_rd_pend      <= 1'b0;
      r_rd_addr      <= '0;
      bist_busy      <= 1'b0;
      bist_done      <= 1'b0;
      bist_fail      <= 1'b0;
      bist_fail_addr <= '0;
      bist_fail_exp  <= 16'h0000;
      bist_fail_act  <= 16'h0000;
      ram_addr       <= '0;
      ram_cen        <= 1'b1;
      ram_wen        <= 2'b11;
      ram_din        <= 16'h0000;
    end else begin
      r_state   <= w_nstate;
      r_addr    <= w_naddr;
      r_ph      <= w_nph;
      r_rd_pend <= (r_state == S_M5) && !r_ph;
      r_rd_addr <= r_addr;
      bist_busy <= (w_nstate != S_IDLE) && (w_nstate != S_DONE);
      bist_done <= (w_nstate == S_DONE);
      ram_addr  <= w_aout;
      ram_cen   <= w_cen;
      ram_wen   <= w_wen;
      ram_din   <= w_din;
      if (w_start) begin
        bist_fail      <= 1'b0;
        bist_fail_addr <= '0;
        bist_fail_exp  <= 16'h0000;
        bist_fail_act  <= 16'h0000;
      end else if (w_mis) begin
        bist_fail      <= 1'b1;
        bist_fail_addr <= w_cmp_addr;
        bist_fail_exp  <= w_cmp_exp;
        bist_fail_act  <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_pu_msp430_ram_bist.sv
// Scoreboard bench for pu_msp430_ram_bist: a 128-word instance with a
// fault-injecting RAM model, and a 2-word instance checked cycle by cycle.
module tb_pu_msp430_ram_bist;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bist_start = 1'b0;
  logic        bist_busy, bist_done, bist_fail;
  logic [6:0]  bist_fail_addr, ram_addr;
  logic [15:0] bist_fail_exp, bist_fail_act, ram_din;
  logic [15:0] ram_dout = 16'h0000;
  logic        ram_cen;
  logic [1:0]  ram_wen;

  logic        start2 = 1'b0;
  logic        busy2, done2, fail2;
  logic [0:0]  fail_addr2, ram_addr2;
  logic [15:0] fail_exp2, fail_act2, ram_din2;
  logic [15:0] ram_dout2 = 16'h0000;
  logic        ram_cen2;
  logic [1:0]  ram_wen2;

  always #5 mclk = ~mclk;

  pu_msp430_ram_bist dut (
    .mclk(mclk), .reset_n(reset_n), .bist_start(bist_start),
    .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail),
    .bist_fail_addr(bist_fail_addr), .bist_fail_exp(bist_fail_exp),
    .bist_fail_act(bist_fail_act), .ram_addr(ram_addr), .ram_cen(ram_cen),
    .ram_wen(ram_wen), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  pu_msp430_ram_bist #(.ADDR_MSB(0), .MEM_SIZE(4), .DATA_BG(16'h0000)) dut2 (
    .mclk(mclk), .reset_n(reset_n), .bist_start(start2),
    .bist_busy(busy2), .bist_done(done2), .bist_fail(fail2),
    .bist_fail_addr(fail_addr2), .bist_fail_exp(fail_exp2),
    .bist_fail_act(fail_act2), .ram_addr(ram_addr2), .ram_cen(ram_cen2),
    .ram_wen(ram_wen2), .ram_din(ram_din2), .ram_dout(ram_dout2)
  );

  // RAM models: fault 1 = bit 3 of word 5 reads as 1;
  // fault 2 = clearing bit 0 of word 9 by a write flips bit 0 of word 8.
  logic [15:0] mem [0:127];
  logic [15:0] mem2 [0:1];
  int          fault = 0;
  logic        clr_mem = 1'b0;

  always @(posedge mclk) begin
    if (clr_mem) begin
      for (int i = 0; i < 128; i++) mem[i] <= 16'h0000;
    end else if (!ram_cen) begin
      if (ram_wen == 2'b00) begin
        mem[ram_addr] <= ram_din;
        if (fault == 2 && ram_addr == 7'd9 && mem[9][0] && !ram_din[0])
          mem[8][0] <= ~mem[8][0];
      end else begin
        ram_dout <= mem[ram_addr] | ((fault == 1 && ram_addr == 7'd5) ? 16'h0008 : 16'h0000);
      end
    end
  end

  always @(posedge mclk) begin
    if (!ram_cen2) begin
      if (ram_wen2 == 2'b00) mem2[ram_addr2] <= ram_din2;
      else                   ram_dout2 <= mem2[ram_addr2];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fail;
    logic [6:0]  addr;
    logic [15:0] exp;
    logic [15:0] act;
    int          busy;
    int          wr;
    int          rd;
  } res_t;

  res_t        q[$];
  logic [19:0] q2[$];
  int          busy_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  logic        done_prev = 1'b0;

  // Monitor for the large instance: tally activity, score each completed run
  always @(negedge mclk) begin
    res_t e;
    if (bist_busy) busy_cnt++;
    if (!ram_cen && ram_wen == 2'b00) wr_cnt++;
    if (!ram_cen && ram_wen == 2'b11) rd_cnt++;
    if (bist_done && !done_prev) begin
      chk("result_available", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fail", bist_fail, e.fail);
        chk("fail_addr", bist_fail_addr, e.addr);
        chk("fail_exp", bist_fail_exp, e.exp);
        chk("fail_act", bist_fail_act, e.act);
        chk("busy_cycles", busy_cnt, e.busy);
        chk("write_count", wr_cnt, e.wr);
        chk("read_count", rd_cnt, e.rd);
        chk("cen_after_done", ram_cen, 1'b1);
        chk("wen_after_done", ram_wen, 2'b11);
      end
    end
    done_prev = bist_done;
  end

  // Monitor for the 2-word instance: every busy cycle must match the next expected access
  always @(negedge mclk) begin
    logic [19:0] e2;
    if (busy2) begin
      chk("seq_available", q2.size() > 0, 1);
      if (q2.size() > 0) begin
        e2 = q2.pop_front();
        chk("seq_access", {ram_cen2, ram_wen2, ram_addr2, ram_din2}, e2);
      end
    end
  end

  task automatic run(input logic push, input res_t e, input logic clear);
    @(posedge mclk); #1;
    if (clear) begin
      clr_mem = 1'b1;
      @(posedge mclk); #1;
      clr_mem = 1'b0;
    end
    if (push) q.push_back(e);
    busy_cnt = 0; wr_cnt = 0; rd_cnt = 0;
    bist_start = 1'b1;
    @(posedge mclk); #1;
    bist_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge mclk);
      if (bist_done) break;
    end
    chk("done_within_budget", bist_done, 1'b1);
  endtask

  function automatic res_t mk(input logic f, input logic [6:0] a, input logic [15:0] x,
                              input logic [15:0] y, input int b, input int w, input int r);
    res_t e;
    e.fail = f; e.addr = a; e.exp = x; e.act = y; e.busy = b; e.wr = w; e.rd = r;
    return e;
  endfunction

  res_t good;
  logic [19:0] seq [21];

  initial begin
    good = mk(1'b0, 7'd0, 16'h0000, 16'h0000, 1281, 640, 640);

    // Reset values while reset_n is held low
    repeat (3) @(posedge mclk);
    #1;
    chk("rst_busy", bist_busy, 1'b0);
    chk("rst_done", bist_done, 1'b0);
    chk("rst_fail", bist_fail, 1'b0);
    chk("rst_fail_addr", bist_fail_addr, 7'd0);
    chk("rst_cen", ram_cen, 1'b1);
    chk("rst_wen", ram_wen, 2'b11);
    chk("rst_addr", ram_addr, 7'd0);
    chk("rst_din", ram_din, 16'h0000);
    reset_n = 1'b1;

    // Good RAM, full run
    run(1'b1, good, 1'b1);
    chk("busy_after_start", bist_busy, 1'b1);
    chk("first_write_cen", ram_cen, 1'b0);
    chk("first_write_wen", ram_wen, 2'b00);
    wait_done(2000);

    // Stuck-at-1 bit 3 of word 5, caught by the M1 read
    fault = 1;
    run(1'b1, mk(1'b1, 7'd5, 16'h0000, 16'h0008, 140, 134, 6), 1'b1);
    wait_done(2000);
    repeat (2) @(negedge mclk);
    chk("stuck_cen_idle", ram_cen, 1'b1);
    chk("stuck_fail_hold", bist_fail, 1'b1);

    // Restart from a failed DONE: status cleared, clean rerun
    fault = 0;
    run(1'b1, good, 1'b1);
    chk("restart_done_clr", bist_done, 1'b0);
    chk("restart_fail_clr", bist_fail, 1'b0);
    chk("restart_addr_clr", bist_fail_addr, 7'd0);
    chk("restart_act_clr", bist_fail_act, 16'h0000);
    wait_done(2000);

    // Coupling fault 9 -> 8, caught in the M3 down element
    fault = 2;
    run(1'b1, mk(1'b1, 7'd8, 16'h0000, 16'h0001, 880, 504, 376), 1'b1);
    wait_done(2000);

    // Start while busy is ignored
    fault = 0;
    run(1'b1, good, 1'b1);
    repeat (500) @(posedge mclk);
    #1 bist_start = 1'b1;
    @(posedge mclk); #1 bist_start = 1'b0;
    wait_done(2000);

    // Reset in the middle of a run
    run(1'b0, good, 1'b1);
    repeat (299) @(posedge mclk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_busy", bist_busy, 1'b0);
    chk("midrst_done", bist_done, 1'b0);
    chk("midrst_cen", ram_cen, 1'b1);
    chk("midrst_wen", ram_wen, 2'b11);
    chk("midrst_addr", ram_addr, 7'd0);
    chk("midrst_din", ram_din, 16'h0000);
    @(posedge mclk); #1 reset_n = 1'b1;
    run(1'b1, good, 1'b0);
    wait_done(2000);

    // 2-word instance: exact access sequence {cen,wen,addr,din}
    seq = '{
      {1'b0, 2'b00, 1'b0, 16'h0000}, {1'b0, 2'b00, 1'b1, 16'h0000},
      {1'b0, 2'b11, 1'b0, 16'h0000}, {1'b0, 2'b00, 1'b0, 16'hFFFF},
      {1'b0, 2'b11, 1'b1, 16'h0000}, {1'b0, 2'b00, 1'b1, 16'hFFFF},
      {1'b0, 2'b11, 1'b0, 16'h0000}, {1'b0, 2'b00, 1'b0, 16'h0000},
      {1'b0, 2'b11, 1'b1, 16'h0000}, {1'b0, 2'b00, 1'b1, 16'h0000},
      {1'b0, 2'b11, 1'b1, 16'h0000}, {1'b0, 2'b00, 1'b1, 16'hFFFF},
      {1'b0, 2'b11, 1'b0, 16'h0000}, {1'b0, 2'b00, 1'b0, 16'hFFFF},
      {1'b0, 2'b11, 1'b1, 16'h0000}, {1'b0, 2'b00, 1'b1, 16'h0000},
      {1'b0, 2'b11, 1'b0, 16'h0000}, {1'b0, 2'b00, 1'b0, 16'h0000},
      {1'b0, 2'b11, 1'b0, 16'h0000}, {1'b0, 2'b11, 1'b1, 16'h0000},
      {1'b1, 2'b11, 1'b0, 16'h0000}
    };
    @(posedge mclk); #1;
    for (int i = 0; i < 21; i++) q2.push_back(seq[i]);
    start2 = 1'b1;
    @(posedge mclk); #1 start2 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge mclk);
      if (done2) break;
    end
    chk("n2_done", done2, 1'b1);
    chk("n2_fail", fail2, 1'b0);
    chk("n2_seq_consumed", q2.size(), 0);

    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
